fwvexrisc_wb_sram_target: RTL and testbench
===========================================

FWVEXRISC_WB_SRAM_TARGET -- requirements
Module: fwvexrisc_wb_sram_target

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits of the attached SRAM (1024 x 32 = 4 KB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address of the window (aligned to 4*2^ADDR_WIDTH).
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have Wishbone target port t_: t_adr in 32, t_dat_w in 32, t_dat_r out 32, t_cyc in 1, t_stb in 1, t_sel in 4, t_we in 1, t_ack out 1, t_err out 1.
REQ-006 SHALL have SRAM port: mem_cs out 1, mem_we out 1, mem_wmask out 4, mem_adr out ADDR_WIDTH, mem_wdat out 32, mem_rdat in 32 (data valid the cycle after a read strobe).

Function
REQ-007 SHALL implement a Wishbone classic target; a beat is requested when t_cyc && t_stb && !t_ack && !t_err and the state is IDLE.
REQ-008 SHALL use states IDLE, RD_WAIT, RESP; transitions: IDLE->RESP on write request; IDLE->RD_WAIT on read request; RD_WAIT->RESP always; RESP->IDLE always.
REQ-009 SHALL drive mem_cs=1 combinationally only in IDLE on a request cycle; mem_adr=t_adr[ADDR_WIDTH+1:2]; mem_we=t_we; mem_wmask=t_sel; mem_wdat=t_dat_w.
REQ-010 SHALL assert t_ack for exactly one cycle, in RESP; write latency request->ack 1 cycle, read latency 2 cycles.
REQ-011 SHALL register mem_rdat into t_dat_r at the RD_WAIT->RESP edge; t_dat_r SHALL hold its value until the next read completes.
REQ-012 SHALL ignore t_stb during the RESP cycle so a held stb with a stale address is never re-serviced; next beat is accepted the cycle after ack.
REQ-013 SHALL return all 32 bits on reads regardless of t_sel; writes SHALL update only bytes with t_sel bit set; t_sel=4'b0000 write SHALL complete with ack and modify nothing.
REQ-014 SHALL support multi-beat bursts under continuous t_cyc with the initiator updating t_adr after each ack; peak rate 1 write per 2 cycles, 1 read per 3 cycles.
REQ-015 SHALL abandon an in-flight read if t_cyc drops in RD_WAIT: go to IDLE, no ack, t_dat_r unchanged.
REQ-016 SHALL never assert t_ack and t_err together.

Reset
REQ-017 SHALL, while reset_n=0 at a clock edge, force state=IDLE, t_ack=0, t_err=0, t_dat_r=32'h0; mem_cs SHALL be 0 throughout reset.
REQ-018 SHALL discard any in-flight beat on reset; no ack for that beat after reset release.

Configuration
REQ-019 SHALL honour macro FWVEXRISC_WB_SRAM_TARGET_ERR_EN.
REQ-020 With FWVEXRISC_WB_SRAM_TARGET_ERR_EN defined: a request whose t_adr lies outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WIDTH) SHALL skip the SRAM (mem_cs=0), go to RESP and assert t_err (not t_ack) for one cycle, 1 cycle after request.
REQ-021 Without it: address bits above ADDR_WIDTH+1 SHALL be ignored (aliasing), t_err SHALL be tied 0.

Structure
REQ-022 SHALL take the state enumeration and Wishbone width constants (address 32, data 32, sel 4) from shared package fwvexrisc_wb_pkg.
REQ-023 SHALL contain no sub-module; the SRAM macro is external; bench model fwvexrisc_sram_1rw (1-cycle read, byte-masked write) lives in the verification tree.

Verification
REQ-024 Write 0xDEADBEEF to 0x10, sel=4'hF -> mem_cs 1 cycle, ack 1 cycle later; read 0x10 -> ack 2 cycles after request, t_dat_r=0xDEADBEEF.
REQ-025 Byte write 0xAA, sel=4'b0100, to word holding 0x11223344 -> readback 0x11AA3344.
REQ-026 8-beat read burst from 0x100 with stb held and adr+4 after each ack -> exactly 8 acks, 24 cycles, correct data each beat, no duplicate ack for stale address.
REQ-027 Drop t_cyc in RD_WAIT -> no ack, t_dat_r unchanged, next request serviced normally.
REQ-028 ERR_EN defined, read 0x0000_1000 with defaults -> t_err 1 cycle, mem_cs never high; undefined -> aliases to word 0, t_ack.
REQ-029 reset_n low during RD_WAIT -> t_ack never asserts, t_dat_r=0, state IDLE after release.

Source files
------------

// File: rtl/fwvexrisc_wb_pkg.sv
// Shared Wishbone constants and the target state encoding for the fwvexrisc bus slaves.
package fwvexrisc_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } wbState_e;

endpackage

// File: rtl/fwvexrisc_wb_sram_target.sv
// Wishbone classic target in front of an external 1-cycle-read, byte-masked SRAM macro.
// Define FWVEXRISC_WB_SRAM_TARGET_ERR_EN to answer out-of-window requests with t_err instead of aliasing.
module fwvexrisc_wb_sram_target
    import fwvexrisc_wb_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 10,
    parameter logic [WB_ADR_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WB_ADR_W-1:0]   t_adr,
    input  logic [WB_DAT_W-1:0]   t_dat_w,
    output logic [WB_DAT_W-1:0]   t_dat_r,
    input  logic                  t_cyc,
    input  logic                  t_stb,
    input  logic [WB_SEL_W-1:0]   t_sel,
    input  logic                  t_we,
    output logic                  t_ack,
    output logic                  t_err,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [WB_SEL_W-1:0]   mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_adr,
    output logic [WB_DAT_W-1:0]   mem_wdat,
    input  logic [WB_DAT_W-1:0]   mem_rdat
);

    wbState_e state;
    logic     request;
    logic     inWindow;
    logic     unusedAdr;

    // The ack/err guard keeps a held strobe from being re-serviced in the response cycle.
    assign request = t_cyc && t_stb && !t_ack && !t_err && (state == IDLE);

`ifdef FWVEXRISC_WB_SRAM_TARGET_ERR_EN
    localparam logic [WB_ADR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [WB_ADR_W:0] WIN_HI = WIN_LO + ({{WB_ADR_W{1'b0}}, 1'b1} << (ADDR_WIDTH + 2));

    assign inWindow  = ({1'b0, t_adr} >= WIN_LO) && ({1'b0, t_adr} < WIN_HI);
    assign unusedAdr = ^t_adr[1:0];
`else
    assign inWindow  = 1'b1;
    assign t_err     = 1'b0;
    assign unusedAdr = ^{t_adr[WB_ADR_W-1:ADDR_WIDTH+2], t_adr[1:0], BASE_ADDR};
`endif

    assign mem_cs    = reset_n && request && inWindow;
    assign mem_we    = t_we;
    assign mem_wmask = t_sel;
    assign mem_adr   = t_adr[ADDR_WIDTH+1:2];
    assign mem_wdat  = t_dat_w;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            t_ack   <= 1'b0;
            t_dat_r <= '0;
`ifdef FWVEXRISC_WB_SRAM_TARGET_ERR_EN
            t_err   <= 1'b0;
`endif
        end else begin
            t_ack <= 1'b0;
`ifdef FWVEXRISC_WB_SRAM_TARGET_ERR_EN
            t_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (request) begin
                        if (!inWindow) begin
                            state <= RESP;
`ifdef FWVEXRISC_WB_SRAM_TARGET_ERR_EN
                            t_err <= 1'b1;
`endif
                        end else if (t_we) begin
                            state <= RESP;
                            t_ack <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // Initiator gave up on the read: drop it without touching the read data.
                    if (!t_cyc) begin
                        state <= IDLE;
                    end else begin
                        state   <= RESP;
                        t_ack   <= 1'b1;
                        t_dat_r <= mem_rdat;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fwvexrisc_wb_sram_target.sv
// Randomized scoreboard bench for fwvexrisc_wb_sram_target with a behavioural SRAM and memory model.
module tb_fwvexrisc_wb_sram_target;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] t_adr, t_dat_w, t_dat_r;
    logic        t_cyc, t_stb, t_we, t_ack, t_err;
    logic [3:0]  t_sel;
    logic        mem_cs, mem_we;
    logic [3:0]  mem_wmask;
    logic [9:0]  mem_adr;
    logic [31:0] mem_wdat, memRdat;

    always #5 clock = ~clock;

    fwvexrisc_wb_sram_target dut (
        .clock(clock), .reset_n(reset_n),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_sel(t_sel), .t_we(t_we),
        .t_ack(t_ack), .t_err(t_err),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_adr(mem_adr), .mem_wdat(mem_wdat), .mem_rdat(memRdat)
    );

    // External SRAM: 1-cycle read, byte-masked write
    logic [31:0] sram [0:1023];
    always @(posedge clock) begin
        if (mem_cs) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) sram[mem_adr][8*b +: 8] <= mem_wdat[8*b +: 8];
            end else begin
                memRdat <= sram[mem_adr];
            end
        end
    end

    typedef struct {
        bit          isErr;
        logic [31:0] data;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    logic [31:0] refMem [0:1023];
    logic [31:0] lastRead;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic bit inWin(input logic [31:0] a);
`ifdef FWVEXRISC_WB_SRAM_TARGET_ERR_EN
        return a < 32'h0000_1000;
`else
        return 1'b1;
`endif
    endfunction

    // Monitor: every response is matched against the oldest expectation
    always @(negedge clock) begin
        if (t_ack || t_err) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got ack=%b err=%b expected no response", t_ack, t_err);
            end else begin
                monE = expQ.pop_front();
                check("resp_err", {31'd0, t_err}, {31'd0, monE.isErr});
                check("resp_ack", {31'd0, t_ack}, {31'd0, !monE.isErr});
                check("resp_rdata", t_dat_r, monE.data);
            end
        end
    end

    task automatic beat(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input bit hold, output int cycles);
        exp_t e;
        int   idx = int'((adr >> 2) & 32'h3FF);
        bit   ok  = inWin(adr);
        int   cs  = 0;
        int   n   = 0;
        bit   done = 0;
        t_cyc = 1'b1; t_stb = 1'b1; t_we = we; t_adr = adr; t_sel = sel; t_dat_w = dat;
        if (ok && we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) refMem[idx][8*b +: 8] = dat[8*b +: 8];
        if (ok && !we) lastRead = refMem[idx];
        e.isErr = !ok;
        e.data  = lastRead;
        expQ.push_back(e);
        while (!done) begin
            @(negedge clock);
            n++;
            if (mem_cs) cs++;
            if (t_ack || t_err) done = 1;
            else if (n > 8) begin
                checks++;
                errors++;
                $display("FAIL resp_timeout: got no response after %0d cycles expected one", n);
                done = 1;
            end
        end
        check("latency", n - 1, (ok && !we) ? 32'd2 : 32'd1);
        check("mem_cs_cycles", cs, ok ? 32'd1 : 32'd0);
        @(posedge clock); #1;
        if (!hold) begin
            t_cyc = 1'b0;
            t_stb = 1'b0;
        end
        cycles = n;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          c, total;
        logic [31:0] adr;
        reset_n = 1'b0; t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        t_adr = '0; t_sel = '0; t_dat_w = '0; lastRead = '0;
        repeat (3) @(negedge clock);
        check("rst_ack", {31'd0, t_ack}, 32'd0);
        check("rst_err", {31'd0, t_err}, 32'd0);
        check("rst_dat_r", t_dat_r, 32'd0);
        check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        for (int i = 0; i < 128; i++) beat(1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, c);

        beat(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, c);
        beat(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, c);
        check("read_deadbeef", t_dat_r, 32'hDEADBEEF);

        beat(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, c);
        beat(1'b1, 32'h20, 4'b0100, 32'hAAAAAAAA, 1'b0, c);
        beat(1'b0, 32'h20, 4'b0001, 32'h0, 1'b0, c);
        check("byte_write", t_dat_r, 32'h11AA3344);
        beat(1'b1, 32'h24, 4'b0000, 32'hFFFFFFFF, 1'b0, c);
        beat(1'b0, 32'h24, 4'hF, 32'h0, 1'b0, c);

        total = 0;
        for (int i = 0; i < 8; i++) begin
            beat(1'b0, 32'h100 + 32'(i * 4), 4'hF, 32'h0, i < 7, c);
            total += c;
        end
        check("read_burst_cycles", total, 32'd24);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 32'h140 + 32'(i * 4), 4'hF, $urandom, i < 3, c);
            total += c;
        end
        check("write_burst_cycles", total, 32'd8);
        repeat (3) @(negedge clock);

        // Abandon a read in RD_WAIT
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h30; t_sel = 4'hF;
        @(posedge clock); #1;
        t_cyc = 1'b0; t_stb = 1'b0;
        repeat (4) @(negedge clock);
        check("abandon_dat_r", t_dat_r, lastRead);
        @(posedge clock); #1;
        beat(1'b0, 32'h30, 4'hF, 32'h0, 1'b0, c);

        beat(1'b0, 32'h0000_1000, 4'hF, 32'h0, 1'b0, c);

        for (int i = 0; i < 60; i++) begin
            adr = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0,
                   3'd0, 7'($urandom_range(0, 127)), 2'($urandom)};
            beat(1'($urandom), adr, 4'($urandom), $urandom, (i < 59) && 1'($urandom), c);
        end

        // Reset during RD_WAIT with the cycle still held
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h40; t_sel = 4'hF;
        @(posedge clock); #1 reset_n = 1'b0;
        @(negedge clock);
        check("rst_rdwait_mem_cs", {31'd0, mem_cs}, 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_rdwait_ack", {31'd0, t_ack}, 32'd0);
        check("rst_rdwait_dat_r", t_dat_r, 32'd0);
        check("rst_held_mem_cs", {31'd0, mem_cs}, 32'd0);
        t_cyc = 1'b0; t_stb = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        lastRead = '0;
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        beat(1'b0, 32'h40, 4'hF, 32'h0, 1'b0, c);

        repeat (3) @(negedge clock);
        check("queue_drained", expQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
